// File: rtl/vpu_issue_queue.sv
// vpu_issue_queue
//   VPU-side consumer of the OVI issue channel. Issued vector instructions
//   are buffered in a DEPTH-entry FIFO. A three-state controller pops one
//   entry at a time into an execution register and holds it for EXEC_LATENCY
//   cycles. It then presents a one-cycle completion built from that entry.
//   Each pop returns one issue credit to the core.
//
// Ports
//   CLK                 in   clock, rising edge
//   RESET               in   asynchronous active-low reset
//   ISSUE_VALID         in   issue strobe (one instruction per cycle)
//   ISSUE_INST          in   [31:0] vector instruction word
//   ISSUE_SCALAR_OPND   in   [63:0] scalar operand
//   ISSUE_SB_ID         in   [4:0]  scoreboard id
//   ISSUE_CREDIT        out  one-cycle pulse per dequeued entry
//   COMPLETED_VALID     out  one-cycle completion pulse
//   COMPLETED_SB_ID     out  [4:0]  sb_id of completing instruction
//   COMPLETED_DEST_REG  out  [63:0] scalar_opnd + zero-extended inst
//   COMPLETED_VXSAT     out  inst[25]
//   COMPLETED_FFLAGS    out  [4:0]  inst[11:7]
//   COUNT               out  FIFO occupancy
//   OVERFLOW            out  sticky: an issue arrived while the FIFO was full
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | execution register empty; pop when the FIFO is non-empty
// EXEC  | counting down the execution latency of the held instruction
// DONE  | completion presented this cycle; pop the next entry if available

module vpu_issue_queue #(
  parameter int DEPTH        = 4,
  parameter int EXEC_LATENCY = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       ISSUE_VALID,
  input  logic [31:0]                ISSUE_INST,
  input  logic [63:0]                ISSUE_SCALAR_OPND,
  input  logic [4:0]                 ISSUE_SB_ID,
  output logic                       ISSUE_CREDIT,
  output logic                       COMPLETED_VALID,
  output logic [4:0]                 COMPLETED_SB_ID,
  output logic [63:0]                COMPLETED_DEST_REG,
  output logic                       COMPLETED_VXSAT,
  output logic [4:0]                 COMPLETED_FFLAGS,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       OVERFLOW
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (EXEC_LATENCY > 1) ? $clog2(EXEC_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0]   mem_inst [DEPTH];
  logic [63:0]   mem_opnd [DEPTH];
  logic [4:0]    mem_sb   [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;

  logic [31:0]   exec_inst;
  logic [63:0]   exec_opnd;
  logic [4:0]    exec_sb;

  logic          full;
  logic          push;
  logic          pop;
  logic          credit;
  logic          overflow;

  // Full is judged on the occupancy before the edge, so a pop on the same
  // edge never makes room for an issue that arrives at a full FIFO.
  assign full = (count == CW'(DEPTH));
  assign push = ISSUE_VALID && !full;

  // ---------------------------------------------------------------------
  // FIFO storage (data needs no reset; occupancy is tracked by count)
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_inst[wr_ptr] <= ISSUE_INST;
      mem_opnd[wr_ptr] <= ISSUE_SCALAR_OPND;
      mem_sb[wr_ptr]   <= ISSUE_SB_ID;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ISSUE_VALID && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      timer     <= '0;
      credit    <= 1'b0;
      exec_inst <= '0;
      exec_opnd <= '0;
      exec_sb   <= '0;
    end else begin
      state  <= state_next;
      credit <= pop;
      if (pop) begin
        exec_inst <= mem_inst[rd_ptr];
        exec_opnd <= mem_opnd[rd_ptr];
        exec_sb   <= mem_sb[rd_ptr];
        timer     <= TW'(EXEC_LATENCY - 1);
      end else if (state == EXEC && timer != '0) begin
        timer <= timer - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (timer == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Back-to-back: the next entry starts while this one completes.
        if (count != '0) begin
          pop        = 1'b1;
          state_next = EXEC;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (completion fields are forced to zero outside DONE)
  // ---------------------------------------------------------------------
  always_comb begin
    COMPLETED_VALID    = 1'b0;
    COMPLETED_SB_ID    = '0;
    COMPLETED_DEST_REG = '0;
    COMPLETED_VXSAT    = 1'b0;
    COMPLETED_FFLAGS   = '0;
    if (state == DONE) begin
      COMPLETED_VALID    = 1'b1;
      COMPLETED_SB_ID    = exec_sb;
      COMPLETED_DEST_REG = exec_opnd + {32'b0, exec_inst};
      COMPLETED_VXSAT    = exec_inst[25];
      COMPLETED_FFLAGS   = exec_inst[11:7];
    end
  end

  assign ISSUE_CREDIT = credit;
  assign COUNT        = count;
  assign OVERFLOW     = overflow;

endmodule

// File: tb/tb_vpu_issue_queue.sv
// Bench for vpu_issue_queue. The reference model is timestamp based:
// every accepted instruction gets an accept edge, a pop edge and a
// completion cycle computed from the queueing rules. Expected outputs for
// any cycle are derived by scanning those timestamps.

module tb_vpu_issue_queue;

  localparam int DEPTH        = 4;
  localparam int EXEC_LATENCY = 8;
  localparam int CW           = $clog2(DEPTH + 1);

  logic          CLK;
  logic          RESET;
  logic          ISSUE_VALID;
  logic [31:0]   ISSUE_INST;
  logic [63:0]   ISSUE_SCALAR_OPND;
  logic [4:0]    ISSUE_SB_ID;
  logic          ISSUE_CREDIT;
  logic          COMPLETED_VALID;
  logic [4:0]    COMPLETED_SB_ID;
  logic [63:0]   COMPLETED_DEST_REG;
  logic          COMPLETED_VXSAT;
  logic [4:0]    COMPLETED_FFLAGS;
  logic [CW-1:0] COUNT;
  logic          OVERFLOW;

  vpu_issue_queue #(.DEPTH(DEPTH), .EXEC_LATENCY(EXEC_LATENCY)) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .ISSUE_VALID        (ISSUE_VALID),
    .ISSUE_INST         (ISSUE_INST),
    .ISSUE_SCALAR_OPND  (ISSUE_SCALAR_OPND),
    .ISSUE_SB_ID        (ISSUE_SB_ID),
    .ISSUE_CREDIT       (ISSUE_CREDIT),
    .COMPLETED_VALID    (COMPLETED_VALID),
    .COMPLETED_SB_ID    (COMPLETED_SB_ID),
    .COMPLETED_DEST_REG (COMPLETED_DEST_REG),
    .COMPLETED_VXSAT    (COMPLETED_VXSAT),
    .COMPLETED_FFLAGS   (COMPLETED_FFLAGS),
    .COUNT              (COUNT),
    .OVERFLOW           (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  logic [31:0] m_inst [$];
  logic [63:0] m_opnd [$];
  logic [4:0]  m_sb   [$];
  int          m_acc  [$];
  int          m_pop  [$];
  int          m_done [$];
  int          last_done = -100;
  bit          m_ovf = 1'b0;

  // observation log (from the DUT) used by directed checks
  int          n_compl = 0;
  int          n_credit = 0;
  logic [63:0] last_dest = '0;
  logic [4:0]  compl_sb [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_count(input int c);
    int n;
    n = 0;
    foreach (m_acc[i]) begin
      if (m_acc[i] <= c) n++;
      if (m_pop[i] <= c) n--;
    end
    return n;
  endfunction

  task automatic model_clear();
    m_inst.delete(); m_opnd.delete(); m_sb.delete();
    m_acc.delete();  m_pop.delete();  m_done.delete();
    last_done = -100;
    m_ovf     = 1'b0;
  endtask

  task automatic check_cycle();
    bit          e_credit, e_valid, e_vx;
    logic [4:0]  e_sb, e_ff;
    logic [63:0] e_dest;
    e_credit = 0; e_valid = 0; e_vx = 0; e_sb = '0; e_ff = '0; e_dest = '0;
    foreach (m_acc[i]) begin
      if (m_pop[i] == cyc) e_credit = 1;
      if (m_done[i] == cyc) begin
        e_valid = 1;
        e_sb    = m_sb[i];
        e_dest  = m_opnd[i] + 64'(m_inst[i]);
        e_vx    = m_inst[i][25];
        e_ff    = m_inst[i][11:7];
      end
    end
    chk("credit",   64'(ISSUE_CREDIT),       64'(e_credit));
    chk("valid",    64'(COMPLETED_VALID),    64'(e_valid));
    chk("sb_id",    64'(COMPLETED_SB_ID),    64'(e_sb));
    chk("dest_reg", COMPLETED_DEST_REG,      e_dest);
    chk("vxsat",    64'(COMPLETED_VXSAT),    64'(e_vx));
    chk("fflags",   64'(COMPLETED_FFLAGS),   64'(e_ff));
    chk("count",    64'(COUNT),              64'(exp_count(cyc)));
    chk("overflow", 64'(OVERFLOW),           64'(m_ovf));
    if (ISSUE_CREDIT) n_credit++;
    if (COMPLETED_VALID) begin
      n_compl++;
      last_dest = COMPLETED_DEST_REG;
      compl_sb.push_back(COMPLETED_SB_ID);
    end
  endtask

  // Called at a negedge: drive inputs for the next edge, update the model,
  // advance one cycle and check the outputs of the new cycle.
  task automatic step(input bit v, input logic [31:0] inst,
                      input logic [63:0] opnd, input logic [4:0] sb);
    int e, p;
    ISSUE_VALID       = v;
    ISSUE_INST        = inst;
    ISSUE_SCALAR_OPND = opnd;
    ISSUE_SB_ID       = sb;
    e = cyc + 1;
    if (v) begin
      if (exp_count(cyc) < DEPTH) begin
        p = (e + 1 > last_done + 1) ? e + 1 : last_done + 1;
        m_inst.push_back(inst); m_opnd.push_back(opnd); m_sb.push_back(sb);
        m_acc.push_back(e); m_pop.push_back(p); m_done.push_back(p + EXEC_LATENCY);
        last_done = p + EXEC_LATENCY;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_credit"}, 64'(ISSUE_CREDIT),    64'd0);
    chk({tag, "_valid"},  64'(COMPLETED_VALID), 64'd0);
    chk({tag, "_dest"},   COMPLETED_DEST_REG,   64'd0);
    chk({tag, "_sb"},     64'(COMPLETED_SB_ID), 64'd0);
    chk({tag, "_count"},  64'(COUNT),           64'd0);
    chk({tag, "_ovf"},    64'(OVERFLOW),        64'd0);
  endtask

  // Asynchronous reset pulse between edges; called at a negedge.
  task automatic pulse_reset();
    ISSUE_VALID = 1'b0;
    #2;
    RESET = 1'b0;
    #1;
    check_zero("rst_async");
    @(posedge CLK); cyc++;
    @(posedge CLK); cyc++;
    @(negedge CLK);
    model_clear();
    check_zero("rst_held");
    RESET = 1'b1;
  endtask

  int c0, n0;

  initial begin
    RESET             = 1'b0;
    ISSUE_VALID       = 1'b0;
    ISSUE_INST        = '0;
    ISSUE_SCALAR_OPND = '0;
    ISSUE_SB_ID       = '0;
    @(negedge CLK);
    @(negedge CLK);
    check_zero("reset");
    RESET = 1'b1;
    cyc   = 0;

    // single issue
    n_credit = 0; n_compl = 0;
    step(1'b1, 32'h0000_0A80, 64'h10, 5'd3);
    idle(12);
    chk("single_credits", 64'(n_credit), 64'd1);
    chk("single_compls",  64'(n_compl),  64'd1);
    chk("single_dest",    last_dest,     64'hA90);

    // burst of DEPTH issues
    n_credit = 0; n_compl = 0; compl_sb.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 32'($urandom), {$urandom, $urandom}, 5'(i));
    idle(40);
    chk("burst_credits", 64'(n_credit), 64'd4);
    chk("burst_compls",  64'(n_compl),  64'd4);
    for (int i = 0; i < 4 && i < compl_sb.size(); i++) chk("burst_order", 64'(compl_sb[i]), 64'(i));

    // overflow: 6 back-to-back issues
    n_credit = 0; n_compl = 0; compl_sb.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 32'($urandom), {$urandom, $urandom}, 5'(i));
    idle(50);
    chk("ovf_flag",    64'(OVERFLOW),   64'd1);
    chk("ovf_credits", 64'(n_credit),   64'd5);
    chk("ovf_compls",  64'(n_compl),    64'd5);
    for (int i = 0; i < 5 && i < compl_sb.size(); i++) chk("ovf_order", 64'(compl_sb[i]), 64'(i));

    // clear the sticky flag, then wrap-around with spaced issues
    pulse_reset();
    n_compl = 0; compl_sb.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'($urandom), {$urandom, $urandom}, 5'(i + 10));
      idle(11);
    end
    idle(10);
    chk("wrap_compls", 64'(n_compl), 64'd10);
    for (int i = 0; i < 10 && i < compl_sb.size(); i++) chk("wrap_order", 64'(compl_sb[i]), 64'(i + 10));
    chk("wrap_count", 64'(COUNT), 64'd0);

    // destination wrap
    step(1'b1, 32'h2, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7);
    idle(12);
    chk("dest_wrap", last_dest, 64'h1);

    // reset mid-EXEC with 2 entries queued
    for (int i = 0; i < 3; i++) step(1'b1, 32'($urandom), {$urandom, $urandom}, 5'(20 + i));
    idle(3);
    chk("pre_rst_count", 64'(COUNT), 64'd2);
    pulse_reset();
    n_credit = 0; n_compl = 0;
    idle(30);
    chk("post_rst_credits", 64'(n_credit), 64'd0);
    chk("post_rst_compls",  64'(n_compl),  64'd0);
    step(1'b1, 32'h0000_0180, 64'h5, 5'd9);
    idle(12);
    chk("fresh_compls", 64'(n_compl), 64'd1);
    chk("fresh_dest",   last_dest,    64'h185);

    // randomized traffic with varying issue density and one mid-run reset
    for (int blk = 0; blk < 12; blk++) begin
      int dens;
      dens = $urandom_range(1, 8);
      if (blk == 6) pulse_reset();
      for (int i = 0; i < 120; i++) begin
        if ($urandom_range(0, 8) < dens)
          step(1'b1, $urandom, {$urandom, $urandom}, 5'($urandom_range(0, 31)));
        else
          step(1'b0, '0, '0, '0);
      end
    end
    idle(60);
    chk("final_count", 64'(COUNT), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vpu_issue_queue.md
Name: vpu_issue_queue

Overview:
- VPU-side consumer of the OVI issue channel. Buffers issued vector instructions in a FIFO, returns one issue credit per dequeued entry, executes each entry with a fixed latency, and emits one completion per instruction back to the OVI block.
- Replaces the ad-hoc fixed-delay completion logic in the top-level harness.
- Sits between the OVI issue/completed interfaces and the VPU datapath.

Parameters:
- DEPTH, 4: FIFO entries; must equal the core's initial issue-credit count; must be ≥1.
- EXEC_LATENCY, 8: EXEC cycles per instruction; must be ≥1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- ISSUE_VALID  in  1  issue strobe, one instruction per cycle high.
- ISSUE_INST  in  32  vector instruction word.
- ISSUE_SCALAR_OPND  in  64  scalar operand.
- ISSUE_SB_ID  in  5  scoreboard id.
- ISSUE_CREDIT  out  1  one-cycle pulse per entry dequeued.
- COMPLETED_VALID  out  1  one-cycle completion pulse.
- COMPLETED_SB_ID  out  5  sb_id of the completing instruction.
- COMPLETED_DEST_REG  out  64  scalar result.
- COMPLETED_VXSAT  out  1  saturation flag.
- COMPLETED_FFLAGS  out  5  FP exception flags.
- COUNT  out  $clog2(DEPTH+1)  current FIFO occupancy.
- OVERFLOW  out  1  sticky error flag.

Behaviour:
- Reset (RESET low, asynchronous):
  - FIFO empty; read and write pointers 0; COUNT=0.
  - FSM in IDLE; latency counter 0.
  - All outputs 0, including OVERFLOW and the COMPLETED_* fields.
- Enqueue:
  - ISSUE_VALID high at an edge with pre-edge COUNT<DEPTH writes {inst, opnd, sb_id} at the write pointer and increments it.
  - Pointers wrap from DEPTH-1 to 0.
  - Full is judged on pre-edge COUNT, so a same-edge pop does not free a slot. Issue with pre-edge COUNT==DEPTH is dropped and sets OVERFLOW, which stays high until reset.
- Pop:
  - Occurs at an edge where FSM is IDLE or DONE and pre-edge COUNT>0.
  - Moves the head entry into the execution register, advances the read pointer and loads counter=EXEC_LATENCY-1.
  - Next state is EXEC. ISSUE_CREDIT is high for exactly the cycle after that edge.
  - Simultaneous enqueue and pop leaves COUNT unchanged.
- FSM:
  - IDLE: COUNT>0 → pop → EXEC; otherwise stay.
  - EXEC: counter>0 → decrement; counter==0 → DONE.
  - DONE: COMPLETED_VALID=1 with fields from the execution register. COUNT>0 → pop → EXEC (back-to-back); otherwise → IDLE.
- Completion data (deterministic model for checking):
  - COMPLETED_SB_ID = sb_id.
  - COMPLETED_DEST_REG = scalar_opnd + {32'b0, inst}, mod 2^64 (wraps).
  - COMPLETED_VXSAT = inst[25].
  - COMPLETED_FFLAGS = inst[11:7].
  - All COMPLETED_* fields are 0 whenever COMPLETED_VALID=0.
- Latency:
  - Issue into an empty idle queue at edge t: credit high in cycle t+1; COMPLETED_VALID high in cycle t+EXEC_LATENCY+1.
  - Back-to-back completions are EXEC_LATENCY+1 cycles apart.
- Order: completions in strict issue order.
- Credit accounting: the number of ISSUE_CREDIT pulses always equals the number of entries popped. No credit is returned for dropped issues.
- Mid-operation reset: in-flight and queued instructions are discarded; no completion or credit is emitted for them.

Test Plan:
- Single issue, EXEC_LATENCY=8: inst=0x0000_0A80, opnd=0x10, sb_id=3 at cycle 0 → ISSUE_CREDIT high in cycle 1 only; COMPLETED_VALID high in cycle 9 only, with sb_id=3, DEST_REG=0xA90, FFLAGS=0x15, VXSAT=0.
- Burst of 4 issues (DEPTH=4), sb_id 0..3, cycles 0–3 → COUNT peaks at 3; completions in cycles 9, 18, 27, 36 with sb_id 0, 1, 2, 3; exactly 4 credit pulses; OVERFLOW=0.
- Overflow: 6 issues on consecutive cycles, sb_id 0..5 → sb_id 5 dropped, OVERFLOW=1; completions for sb_id 0..4 only; 5 credits total.
- Wrap-around: 10 issues spaced 12 cycles apart → pointers wrap twice; all 10 complete in order; COUNT returns to 0.
- DEST_REG wrap: opnd=0xFFFF_FFFF_FFFF_FFFF, inst=0x2 → DEST_REG=0x1.
- Reset asserted asynchronously mid-EXEC with 2 entries queued → all outputs 0 immediately; after release, no completion or credit for the discarded entries; a fresh issue completes normally.
